// File: rtl/traffic_go_tick_gen_if.sv
// traffic_go_tick_gen_if: run-control requests in, go/status out.
// Signals:
//   start_i, stop_i, hold_i  operator/emergency request levels (master -> slave)
//   go                       one-cycle time-unit pulse (slave -> master)
//   run_state                00 STOP, 01 RUN, 10 HOLD
//   hold_timeout             sticky watchdog-exit flag
//   tick_cnt                 count of go pulses issued
interface traffic_go_tick_gen_if;
    logic        start_i;
    logic        stop_i;
    logic        hold_i;
    logic        go;
    logic [1:0]  run_state;
    logic        hold_timeout;
    logic [15:0] tick_cnt;
    modport master(output start_i, stop_i, hold_i, input go, run_state, hold_timeout, tick_cnt);
    modport slave(input start_i, stop_i, hold_i, output go, run_state, hold_timeout, tick_cnt);
endinterface

// File: rtl/traffic_go_tick_gen.sv
// traffic_go_tick_gen: go-pulse timebase gated by a STOP/RUN/HOLD run controller.
// Ports:
//   clk  clock, rising edge
//   Rst  asynchronous active-high reset
//   bus  slave side of traffic_go_tick_gen_if (start_i/stop_i/hold_i in;
//        go/run_state/hold_timeout/tick_cnt out, all registered)
// Optional build macro TICK_DEBOUNCE_EN: adds a 2-FF synchroniser plus a
// DB_CYC-cycle stability filter on each request input.
module traffic_go_tick_gen #(
    parameter int DIV      = 50,
    parameter int DIV_W    = 6,
    parameter int HOLD_MAX = 31,
    parameter int HOLD_W   = 5,
    parameter int DB_CYC   = 4
) (
    input  logic                     clk,
    input  logic                     Rst,
    traffic_go_tick_gen_if.slave     bus
);
    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    logic              start_f;
    logic              stop_f;
    logic              hold_f;
    logic [1:0]        state;
    logic [DIV_W-1:0]  pre;
    logic [DIV_W-1:0]  hold_pre;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_block;
    logic              hold_to;
    logic              go_q;
    logic [15:0]       tick_q;
`ifdef TICK_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYC + 1);
    logic [2:0] raw;
    logic [2:0] filt;
    assign raw = {bus.start_i, bus.stop_i, bus.hold_i};
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic            s1;
        logic            s2;
        logic            f;
        logic [DB_W-1:0] cnt;
        // The filtered level flips only after the synchronised input has
        // disagreed with it for DB_CYC consecutive cycles.
        always_ff @(posedge clk or posedge Rst) begin
            if (Rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                f   <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                if (s2 == f)
                    cnt <= '0;
                else if (cnt == DB_W'(DB_CYC - 1)) begin
                    cnt <= '0;
                    f   <= s2;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
        assign filt[i] = f;
    end
    assign {start_f, stop_f, hold_f} = filt;
`else
    assign {start_f, stop_f, hold_f} = {bus.start_i, bus.stop_i, bus.hold_i};
`endif
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_STOP;
            pre        <= '0;
            hold_pre   <= '0;
            hold_cnt   <= '0;
            hold_block <= 1'b0;
            hold_to    <= 1'b0;
            go_q       <= 1'b0;
            tick_q     <= '0;
        end else begin
            go_q <= 1'b0;
            if (!hold_f)
                hold_block <= 1'b0;
            if (stop_f) begin
                state   <= ST_STOP;
                pre     <= '0;
                hold_to <= 1'b0;
            end else if (state == ST_STOP) begin
                if (start_f) begin
                    state <= ST_RUN;
                    pre   <= '0;
                end
            end else if (state == ST_RUN) begin
                // Hold beats a pending wrap: prescaler is frozen, so the
                // missed go fires on the first RUN edge after resume.
                if (hold_f && !hold_block) begin
                    state    <= ST_HOLD;
                    hold_pre <= '0;
                    hold_cnt <= '0;
                end else if (pre == DIV_W'(DIV - 1)) begin
                    pre    <= '0;
                    go_q   <= 1'b1;
                    tick_q <= tick_q + 1'b1;
                end else
                    pre <= pre + 1'b1;
            end else if (state == ST_HOLD) begin
                if (!hold_f)
                    state <= ST_RUN;
                else if (hold_pre == DIV_W'(DIV - 1)) begin
                    hold_pre <= '0;
                    hold_cnt <= hold_cnt + 1'b1;
                    // Watchdog expiry: leave HOLD and ignore hold_i until it drops.
                    if (hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
                        state      <= ST_RUN;
                        hold_to    <= 1'b1;
                        hold_block <= 1'b1;
                    end
                end else
                    hold_pre <= hold_pre + 1'b1;
            end else
                state <= ST_STOP;
        end
    end
    assign bus.go           = go_q;
    assign bus.run_state    = state;
    assign bus.hold_timeout = hold_to;
    assign bus.tick_cnt     = tick_q;
endmodule

// File: tb/tb_traffic_go_tick_gen.sv
// tb_traffic_go_tick_gen: directed vector bench for traffic_go_tick_gen (DIV=4, HOLD_MAX=3).
module tb_traffic_go_tick_gen;
    typedef struct {
        logic        start;
        logic        stop;
        logic        hold;
        logic        go;
        logic [1:0]  st;
        logic        to;
        logic [15:0] tick;
    } vec_t;
    logic clk = 1'b0;
    logic Rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];
    traffic_go_tick_gen_if bus();
    traffic_go_tick_gen #(.DIV(4), .DIV_W(2), .HOLD_MAX(3), .HOLD_W(2), .DB_CYC(4)) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic add(input int n, input logic s, input logic p, input logic h,
                       input logic g, input logic [1:0] st, input logic to, input logic [15:0] t);
        vec_t v;
        v.start = s; v.stop = p; v.hold = h; v.go = g; v.st = st; v.to = to; v.tick = t;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask
    task automatic set_in(input logic s, input logic p, input logic h);
        bus.start_i = s;
        bus.stop_i  = p;
        bus.hold_i  = h;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        set_in(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset go", bus.go, 0);
        chk("reset state", bus.run_state, 0);
        chk("reset timeout", bus.hold_timeout, 0);
        chk("reset tick", bus.tick_cnt, 0);
`ifdef TICK_DEBOUNCE_EN
        Rst = 1'b0;
        set_in(1, 0, 0);
        repeat (3) @(negedge clk);
        set_in(0, 0, 0);
        repeat (10) @(negedge clk);
        chk("db short pulse", bus.run_state, 0);
        set_in(1, 0, 0);
        repeat (6) @(negedge clk);
        chk("db before latency", bus.run_state, 0);
        @(negedge clk);
        chk("db run entered", bus.run_state, 1);
        repeat (3) @(negedge clk);
        set_in(0, 0, 0);
        chk("db still run", bus.run_state, 1);
`else
        // start -> go every 4 cycles
        add(1, 1,0,0, 0,1,0,0);
        add(3, 0,0,0, 0,1,0,0);
        add(1, 0,0,0, 1,1,0,1);
        add(3, 0,0,0, 0,1,0,1);
        add(1, 0,0,0, 1,1,0,2);
        // short hold with prescaler at 2, resume two cycles before go
        add(2, 0,0,0, 0,1,0,2);
        add(6, 0,0,1, 0,2,0,2);
        add(2, 0,0,0, 0,1,0,2);
        add(1, 0,0,0, 1,1,0,3);
        // long hold -> watchdog exit after 12 cycles, hold_i blocked
        add(12, 0,0,1, 0,2,0,3);
        add(4, 0,0,1, 0,1,1,3);
        add(1, 0,0,1, 1,1,1,4);
        add(3, 0,0,1, 0,1,1,4);
        add(1, 0,0,1, 1,1,1,5);
        add(1, 0,0,0, 0,1,1,5);
        add(1, 0,0,1, 0,2,1,5);
        // stop from HOLD, start+stop together, restart keeps tick_cnt
        add(1, 0,1,1, 0,0,0,5);
        add(1, 1,1,0, 0,0,0,5);
        add(1, 0,0,0, 0,0,0,5);
        add(1, 1,0,0, 0,1,0,5);
        add(3, 0,0,0, 0,1,0,5);
        add(1, 0,0,0, 1,1,0,6);
        Rst = 1'b0;
        foreach (tbl[k]) begin
            set_in(tbl[k].start, tbl[k].stop, tbl[k].hold);
            @(negedge clk);
            chk($sformatf("v%0d go", k), bus.go, tbl[k].go);
            chk($sformatf("v%0d state", k), bus.run_state, tbl[k].st);
            chk($sformatf("v%0d timeout", k), bus.hold_timeout, tbl[k].to);
            chk($sformatf("v%0d tick", k), bus.tick_cnt, tbl[k].tick);
        end
        set_in(0, 0, 0);
        force dut.tick_q = 16'hFFFF;
        #1;
        release dut.tick_q;
        repeat (3) @(negedge clk);
        chk("wrap pre go", bus.go, 0);
        chk("wrap pre tick", bus.tick_cnt, 16'hFFFF);
        @(negedge clk);
        chk("wrap go", bus.go, 1);
        chk("wrap tick", bus.tick_cnt, 0);
        #2 Rst = 1'b1;
        #1;
        chk("async rst go", bus.go, 0);
        chk("async rst state", bus.run_state, 0);
        chk("async rst tick", bus.tick_cnt, 0);
        @(negedge clk);
        Rst = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
